accum_ctrl: RTL and testbench

ACCUM_CTRL -- requirements
Module: accum_ctrl

---
 rtl/accum_ctrl_pkg.sv | 27 ++
 rtl/accum_tag_fifo.sv | 66 ++++++
 rtl/accum_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_accum_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_ctrl_pkg.sv
// Shared types and constants for the accumulator controller:
// the complex sample type, the minimum job length, the FSM state
// encoding and a saturating counter helper.
package accum_ctrl_pkg;

    localparam int ACC_MIN_LEN = 12;
    localparam int CPLX_W      = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    // Adds a small increment to a 16-bit event counter, pinning at 0xFFFF.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] w_sum;
        w_sum = {1'b0, a} + {15'd0, inc};
        return w_sum[16] ? 16'hFFFF : w_sum[15:0];
    endfunction

endpackage

// File: rtl/accum_tag_fifo.sv
// Tag FIFO tracking jobs whose accumulator result has not yet returned.
// A push and a pop in the same cycle both take effect, even when full.
module accum_tag_fifo
    import accum_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];

    // A pop frees the slot this cycle, so a push into a full FIFO is legal alongside it.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/accum_ctrl.sv
// Accumulator job controller: accepts jobs, streams len samples into an
// external accumulator with start/stop framing, enforces an idle gap
// between jobs and tags returning results in issue order.
// Optional statistics counters are enabled by defining ACCUM_CTRL_STATS_EN.
module accum_ctrl
    import accum_ctrl_pkg::*;
#(
    parameter int LEN_W      = 9,
    parameter int TAG_W      = 4,
    parameter int TAG_DEPTH  = 4,
    parameter int GAP_CYCLES = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [LEN_W-1:0] job_len,
    input  logic [TAG_W-1:0] job_tag,
    input  logic             in_valid,
    output logic             in_ready,
    input  complex_t         in_data,
    output complex_t         acc_in,
    output logic             acc_start,
    output logic             acc_stop,
    input  logic             acc_output_valid,
    input  complex_t         acc_out,
    output logic             res_valid,
    output complex_t         res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             job_err,
    output logic             stream_err
`ifdef ACCUM_CTRL_STATS_EN
    ,
    output logic [15:0]      stat_jobs,
    output logic [15:0]      stat_errs
`endif
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [LEN_W-1:0] r_beat;
    logic [LEN_W-1:0] r_len;
    logic [TAG_W-1:0] r_tag;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_job_err;
    logic             r_stream_err;
    logic             r_res_valid;
    complex_t         r_res_data;
    logic [TAG_W-1:0] r_res_tag;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [TAG_W-1:0] w_fifo_head;
    logic             w_accept;
    logic             w_short;
    logic             w_last_beat;
    logic             w_gap_done;
    logic             w_push;
    logic             w_pop;
    logic             w_stream_gap;
    logic             w_orphan_pop;

    assign w_accept     = job_valid && job_ready;
    assign w_short      = (job_len < LEN_W'(ACC_MIN_LEN));
    assign w_last_beat  = (r_beat == r_len - 1'b1);
    // The IDLE cycle that accepts the next job is the last of the forced idle
    // cycles, so GAP itself lasts one cycle less than GAP_CYCLES.
    assign w_gap_done   = (r_gap_cnt == GAP_W'(GAP_CYCLES - 2));
    assign w_pop        = acc_output_valid && !reset;
    assign w_stream_gap = in_ready && !in_valid;
    assign w_orphan_pop = w_pop && w_fifo_empty;

    assign job_err    = r_job_err;
    assign stream_err = r_stream_err;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_tag    = r_res_tag;

    accum_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (r_tag),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; short jobs are dropped without leaving IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_short) w_next_state = STREAM;
            STREAM:  if (w_last_beat)          w_next_state = GAP;
            GAP:     if (w_gap_done)           w_next_state = IDLE;
            default:                           w_next_state = IDLE;
        endcase
    end

    // FSM outputs; reset forces every output low, so an aborted job never sees acc_stop.
    always_comb begin
        job_ready = !reset && (r_state == IDLE) && !w_fifo_full;
        in_ready  = !reset && (r_state == STREAM);
        acc_start = in_ready && (r_beat == '0);
        acc_stop  = in_ready && w_last_beat;
        acc_in    = (in_ready && in_valid) ? in_data : '0;
        w_push    = acc_stop;
    end

    // Beat and gap counters; the beat counter runs every STREAM cycle regardless of in_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat    <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) r_beat <= '0;
                    r_gap_cnt <= '0;
                end
                STREAM: begin
                    r_beat    <= r_beat + 1'b1;
                    r_gap_cnt <= '0;
                end
                GAP: begin
                    r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                default: begin
                    r_beat    <= '0;
                    r_gap_cnt <= '0;
                end
            endcase
        end
    end

    // Job descriptor latched on acceptance.
    always_ff @(posedge clk) begin
        if ((r_state == IDLE) && w_accept) begin
            r_len <= job_len;
            r_tag <= job_tag;
        end
    end

    // Error flags and tagged result, registered one cycle after acc_output_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_job_err    <= 1'b0;
            r_stream_err <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_tag    <= '0;
        end else begin
            r_job_err   <= w_accept && w_short;
            r_res_valid <= w_pop && !w_fifo_empty;
            if (w_stream_gap || w_orphan_pop) begin
                r_stream_err <= 1'b1;
            end
            if (w_pop && !w_fifo_empty) begin
                r_res_data <= acc_out;
                r_res_tag  <= w_fifo_head;
            end
        end
    end

`ifdef ACCUM_CTRL_STATS_EN
    logic [15:0] r_stat_jobs;
    logic [15:0] r_stat_errs;

    assign stat_jobs = r_stat_jobs;
    assign stat_errs = r_stat_errs;

    // Saturating counts of accepted jobs and of error events.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_jobs <= '0;
            r_stat_errs <= '0;
        end else begin
            r_stat_jobs <= sat_add16(r_stat_jobs, {1'b0, w_accept && !w_short});
            r_stat_errs <= sat_add16(r_stat_errs,
                                     {1'b0, w_accept && w_short} +
                                     {1'b0, w_stream_gap || w_orphan_pop});
        end
    end
`endif

endmodule

// File: tb/tb_accum_ctrl.sv
// Directed bench for accum_ctrl: framing, short-job drop, gap timing,
// stream errors, tag FIFO ordering/full handling and mid-job reset.
module tb_accum_ctrl;
    import accum_ctrl_pkg::*;

    localparam int LEN_W = 9;
    localparam int TAG_W = 4;
    localparam int DEPTH = 4;
    localparam int G     = 12;

    logic             clk = 1'b0;
    logic             reset;
    logic             job_valid;
    logic             job_ready;
    logic [LEN_W-1:0] job_len;
    logic [TAG_W-1:0] job_tag;
    logic             in_valid;
    logic             in_ready;
    complex_t         in_data;
    complex_t         acc_in;
    logic             acc_start;
    logic             acc_stop;
    logic             acc_output_valid;
    complex_t         acc_out;
    logic             res_valid;
    complex_t         res_data;
    logic [TAG_W-1:0] res_tag;
    logic             job_err;
    logic             stream_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    accum_ctrl #(
        .LEN_W(LEN_W), .TAG_W(TAG_W), .TAG_DEPTH(DEPTH), .GAP_CYCLES(G)
    ) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len), .job_tag(job_tag),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .acc_in(acc_in), .acc_start(acc_start), .acc_stop(acc_stop),
        .acc_output_valid(acc_output_valid), .acc_out(acc_out),
        .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
        .job_err(job_err), .stream_err(stream_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic complex_t mk(input int re, input int im);
        complex_t c;
        c.re = 16'(re);
        c.im = 16'(im);
        return c;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int len, input int tag);
        job_valid = 1'b1;
        job_len   = LEN_W'(len);
        job_tag   = TAG_W'(tag);
        #2;
        check("offer_ready", job_ready, 1);
        cyc();
        job_valid = 1'b0;
    endtask

    // Streams beats 0..len-1 (stopping early at abort); skip drops in_valid on one beat.
    task automatic stream(input int len, input int skip, input int aov_beat, input int abort);
        complex_t exp_in;
        for (int b = 0; b < len; b++) begin
            if (b == abort) return;
            in_valid         = (b != skip);
            in_data          = mk(b + 1, -2 * (b + 1));
            acc_output_valid = (b == aov_beat);
            acc_out          = mk(100 + b, 0);
            exp_in           = (b == skip) ? '0 : mk(b + 1, -2 * (b + 1));
            #2;
            check("acc_start", acc_start, (b == 0));
            check("acc_stop", acc_stop, (b == len - 1));
            check("in_ready_stream", in_ready, 1);
            check("job_ready_stream", job_ready, 0);
            check("acc_in", acc_in, exp_in);
            cyc();
        end
        in_valid         = 1'b0;
        acc_output_valid = 1'b0;
    endtask

    // Called in the first cycle after acc_stop; walks the gap and the IDLE cycle.
    task automatic gap_wait(input logic exp_ready);
        for (int i = 1; i < G; i++) begin
            #2;
            check("gap_job_ready", job_ready, 0);
            check("gap_in_ready", in_ready, 0);
            cyc();
        end
        #2;
        check("idle_job_ready", job_ready, exp_ready);
        check("idle_in_ready", in_ready, 0);
        cyc();
    endtask

    task automatic pop(input complex_t v, input int tag);
        acc_output_valid = 1'b1;
        acc_out          = v;
        cyc();
        acc_output_valid = 1'b0;
        acc_out          = '0;
        #2;
        check("res_valid", res_valid, 1);
        check("res_tag", res_tag, tag);
        check("res_data", res_data, v);
        cyc();
        check("res_pulse", res_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_start [2];
        int n_st;
        int n_sp;
        int n_acc;

        reset = 1'b1; job_valid = 1'b0; job_len = '0; job_tag = '0;
        in_valid = 1'b0; in_data = '0; acc_output_valid = 1'b0; acc_out = '0;
        repeat (2) cyc();
        #2;
        check("rst_job_ready", job_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_stream_err", stream_err, 0);
        check("rst_job_err", job_err, 0);
        check("rst_acc_start", acc_start, 0);
        cyc();
        reset = 1'b0;
        #2;
        check("post_rst_job_ready", job_ready, 1);
        cyc();

        // Basic job: len 16, tag 3
        offer(16, 3);
        stream(16, -1, -1, -1);
        #1;
        check("t1_stream_err", stream_err, 0);
        gap_wait(1'b1);
        pop(mk(136, -272), 3);

        // Short job dropped
        job_valid = 1'b1; job_len = 9'd11; job_tag = 4'd5;
        #2;
        check("short_ready", job_ready, 1);
        cyc();
        job_valid = 1'b0;
        #2;
        check("short_job_err", job_err, 1);
        check("short_no_start", acc_start, 0);
        check("short_in_ready", in_ready, 0);
        check("short_job_ready", job_ready, 1);
        cyc();
        check("short_err_pulse", job_err, 0);

        // Back-to-back len-12 jobs: start spacing
        n_st = 0; n_sp = 0; n_acc = 0;
        t_start[0] = 0; t_start[1] = 0;
        job_valid = 1'b1; job_len = 9'd12; job_tag = 4'd1;
        in_valid = 1'b1; in_data = mk(5, 5);
        for (int k = 0; k < 80; k++) begin
            #2;
            if (acc_start && n_st < 2) begin
                t_start[n_st] = k;
                n_st++;
            end
            if (acc_stop) n_sp++;
            if (job_valid && job_ready) n_acc++;
            cyc();
            if (n_acc == 1) job_tag = 4'd2;
            if (n_acc >= 2) job_valid = 1'b0;
            if (n_sp == 2) break;
        end
        in_valid = 1'b0;
        job_valid = 1'b0;
        check("b2b_starts", n_st, 2);
        check("b2b_spacing", t_start[1] - t_start[0], 12 + G);
        gap_wait(1'b1);
        pop(mk(10, 20), 1);
        pop(mk(30, 40), 2);

        // Fill the tag FIFO
        for (int j = 0; j < 4; j++) begin
            offer(12, 10 + j);
            stream(12, -1, -1, -1);
            gap_wait(j < 3);
        end
        #2;
        check("full_job_ready", job_ready, 0);
        cyc();
        acc_output_valid = 1'b1; acc_out = mk(-5, 6);
        cyc();
        acc_output_valid = 1'b0;
        #2;
        check("full_pop_valid", res_valid, 1);
        check("full_pop_tag", res_tag, 10);
        check("full_pop_ready", job_ready, 1);
        cyc();

        // Simultaneous push and pop on the last beat
        offer(12, 14);
        stream(12, -1, 11, -1);
        #1;
        check("pp_res_valid", res_valid, 1);
        check("pp_res_tag", res_tag, 11);
        check("pp_res_data", res_data, mk(111, 0));
        gap_wait(1'b1);
        pop(mk(1, 1), 12);
        pop(mk(2, 2), 13);

        // Reset mid-stream (tag 14 still queued)
        offer(30, 9);
        stream(30, -1, -1, 7);
        in_valid = 1'b1; in_data = mk(8, -16); reset = 1'b1;
        #2;
        check("abort_acc_stop", acc_stop, 0);
        check("abort_acc_start", acc_start, 0);
        check("abort_acc_in", acc_in, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_job_ready", job_ready, 0);
        cyc();
        reset = 1'b0; in_valid = 1'b0;
        job_valid = 1'b1; job_len = 9'd12; job_tag = 4'd4;
        acc_output_valid = 1'b1; acc_out = mk(9, 9);
        #2;
        check("abort_new_ready", job_ready, 1);
        check("abort_res_valid", res_valid, 0);
        check("abort_stream_err", stream_err, 0);
        check("abort_no_stop", acc_stop, 0);
        cyc();
        job_valid = 1'b0; acc_output_valid = 1'b0;
        #1;
        check("empty_pop_res", res_valid, 0);
        check("empty_pop_err", stream_err, 1);
        stream(12, -1, -1, -1);
        gap_wait(1'b1);
        pop(mk(44, -44), 4);

        // Missing sample mid-stream
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #2;
        check("clr_stream_err", stream_err, 0);
        cyc();
        offer(20, 7);
        stream(20, 5, -1, -1);
        #1;
        check("gap_stream_err", stream_err, 1);
        gap_wait(1'b1);
        pop(mk(7, 7), 7);
        check("sticky_stream_err", stream_err, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
